// File: rtl/mcsr_file.sv
// Machine-mode CSR file for the writeback stage: M-mode trap state, interrupt
// enables, 64-bit cycle/instret counters and combinational read port for decode.
module mcsr_file #(
    parameter int          NUM_LIRQ  = 4,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter int          CNT_W     = 64
) (
    input  logic                clk,
    input  logic                cpurst,
    input  logic [11:0]         csr_r_index,
    output logic [31:0]         csr_rdat,
    output logic                csr_r_illegal,
    input  logic                csr_wr_en,
    input  logic [1:0]          csr_wr_op,
    input  logic [11:0]         csr_wr_index,
    input  logic [31:0]         csr_wr_src,
    output logic                csr_wr_illegal,
    input  logic                trap_en,
    input  logic                trap_int,
    input  logic [4:0]          trap_cause,
    input  logic [31:0]         trap_pc,
    input  logic [31:0]         trap_tval,
    input  logic                mret,
    input  logic                instret_inc,
    input  logic                mip_msip,
    input  logic                mip_mtip,
    input  logic                mip_meip,
    input  logic [NUM_LIRQ-1:0] lirq,
    output logic                g_int,
    output logic [4:0]          causecode_int,
    output logic [31:0]         trap_vector,
    output logic [31:0]         mepc,
    output logic                mstatus_mie
);

    localparam logic [31:0] MIE_MASK = 32'h0000_0888 | (((32'h1 << NUM_LIRQ) - 32'h1) << 16);
    localparam logic [31:0] INH_MASK = 32'h0000_0005;

    logic              mie_bit_q, mie_bit_d;
    logic              mpie_q, mpie_d;
    logic [31:0]       mie_q, mie_d;
    logic [31:0]       mtvec_q, mtvec_d;
    logic [31:0]       minh_q, minh_d;
    logic [31:0]       mscratch_q, mscratch_d;
    logic [31:0]       mepc_q, mepc_d;
    logic [31:0]       mcause_q, mcause_d;
    logic [31:0]       mtval_q, mtval_d;
    logic [CNT_W-1:0]  mcycle_q, mcycle_d;
    logic [CNT_W-1:0]  minstret_q, minstret_d;

    logic [31:0] mip_s;
    logic [31:0] pend_s;
    logic [63:0] cyc64_s;
    logic [63:0] ret64_s;
    logic        r_hit_s, w_hit_s, w_ro_s;
    logic [31:0] rdat_s, wr_cur_s, wr_new_s;
    logic        wr_do_s;
    logic [4:0]  cause_s;

    // Shared read decode for the decode-stage port and the read-modify-write path.
    function automatic logic [32:0] csr_read(input logic [11:0] idx);
        logic [32:0] r;
        case (idx)
            12'hF11, 12'hF12, 12'hF13, 12'hF14: r = {1'b1, 32'h0000_0000};
            12'h300: r = {1'b1, 19'h0, 2'b11, 3'b000, mpie_q, 3'b000, mie_bit_q, 3'b000};
            12'h301: r = {1'b1, 32'h0000_0000};
            12'h304: r = {1'b1, mie_q};
            12'h305: r = {1'b1, mtvec_q};
            12'h320: r = {1'b1, minh_q};
            12'h340: r = {1'b1, mscratch_q};
            12'h341: r = {1'b1, mepc_q};
            12'h342: r = {1'b1, mcause_q};
            12'h343: r = {1'b1, mtval_q};
            12'h344: r = {1'b1, mip_s};
            12'hB00: r = {1'b1, cyc64_s[31:0]};
            12'hB80: r = {1'b1, cyc64_s[63:32]};
            12'hB02: r = {1'b1, ret64_s[31:0]};
            12'hB82: r = {1'b1, ret64_s[63:32]};
            default: r = {1'b0, 32'h0000_0000};
        endcase
        return r;
    endfunction

    // Live interrupt levels mapped onto the mip layout.
    always_comb begin
        mip_s                 = 32'h0000_0000;
        mip_s[3]              = mip_msip;
        mip_s[7]              = mip_mtip;
        mip_s[11]             = mip_meip;
        mip_s[16 +: NUM_LIRQ] = lirq;
    end

    // Read port, write decode and the read-modify-write operand.
    always_comb begin
        cyc64_s           = 64'(mcycle_q);
        ret64_s           = 64'(minstret_q);
        {r_hit_s, rdat_s} = csr_read(csr_r_index);
        {w_hit_s, wr_cur_s} = csr_read(csr_wr_index);
        w_ro_s            = (csr_wr_index[11:10] == 2'b11) || (csr_wr_index == 12'h344);
        case (csr_wr_op)
            2'b01:   wr_new_s = csr_wr_src;
            2'b10:   wr_new_s = wr_cur_s | csr_wr_src;
            2'b11:   wr_new_s = wr_cur_s & ~csr_wr_src;
            default: wr_new_s = wr_cur_s;
        endcase
        wr_do_s = csr_wr_en && w_hit_s && !w_ro_s && (csr_wr_op != 2'b00) && !trap_en && !mret;
    end

    // Interrupt arbitration: lowest local line wins among lirq, fixed order above.
    always_comb begin
        pend_s  = mip_s & mie_q;
        cause_s = 5'd0;
        for (int i = NUM_LIRQ - 1; i >= 0; i--) begin
            cause_s = pend_s[16 + i] ? 5'(16 + i) : cause_s;
        end
        cause_s = pend_s[7]  ? 5'd7  : cause_s;
        cause_s = pend_s[3]  ? 5'd3  : cause_s;
        cause_s = pend_s[11] ? 5'd11 : cause_s;
    end

    // Next state: trap beats mret beats CSR write; counter writes pre-empt the increment.
    always_comb begin
        mie_bit_d  = mie_bit_q;
        mpie_d     = mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        minh_d     = minh_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mcycle_d   = minh_q[0] ? mcycle_q : mcycle_q + CNT_W'(1);
        minstret_d = (minh_q[2] || !instret_inc) ? minstret_q : minstret_q + CNT_W'(1);
        if (trap_en) begin
            mepc_d     = trap_pc;
            mcause_d   = {trap_int, 26'h0, trap_cause};
            mtval_d    = trap_int ? 32'h0000_0000 : trap_tval;
            mpie_d     = mie_bit_q;
            mie_bit_d  = 1'b0;
        end else if (mret) begin
            mie_bit_d  = mpie_q;
            mpie_d     = 1'b1;
        end else if (wr_do_s) begin
            case (csr_wr_index)
                12'h300: begin
                    mie_bit_d = wr_new_s[3];
                    mpie_d    = wr_new_s[7];
                end
                12'h304: mie_d      = wr_new_s & MIE_MASK;
                12'h305: mtvec_d    = {wr_new_s[31:2], 1'b0, wr_new_s[0] & ~wr_new_s[1]};
                12'h320: minh_d     = wr_new_s & INH_MASK;
                12'h340: mscratch_d = wr_new_s;
                12'h341: mepc_d     = {wr_new_s[31:2], 2'b00};
                12'h342: mcause_d   = wr_new_s;
                12'h343: mtval_d    = wr_new_s;
                12'hB00: mcycle_d   = CNT_W'({cyc64_s[63:32], wr_new_s});
                12'hB80: mcycle_d   = CNT_W'({wr_new_s, cyc64_s[31:0]});
                12'hB02: minstret_d = CNT_W'({ret64_s[63:32], wr_new_s});
                12'hB82: minstret_d = CNT_W'({wr_new_s, ret64_s[31:0]});
                default: mscratch_d = mscratch_q;
            endcase
        end else begin
            mepc_d = mepc_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            mie_bit_q  <= 1'b0;
            mpie_q     <= 1'b0;
            mie_q      <= 32'h0000_0000;
            mtvec_q    <= MTVEC_RST;
            minh_q     <= 32'h0000_0000;
            mscratch_q <= 32'h0000_0000;
            mepc_q     <= 32'h0000_0000;
            mcause_q   <= 32'h0000_0000;
            mtval_q    <= 32'h0000_0000;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mie_bit_q  <= mie_bit_d;
            mpie_q     <= mpie_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            minh_q     <= minh_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

    assign csr_rdat       = rdat_s;
    assign csr_r_illegal  = !r_hit_s;
    assign csr_wr_illegal = csr_wr_en && (!w_hit_s || w_ro_s);
    assign g_int          = mie_bit_q && (pend_s != 32'h0000_0000);
    assign causecode_int  = cause_s;
    assign trap_vector    = (mtvec_q[1:0] == 2'b01 && trap_int)
                            ? {mtvec_q[31:2], 2'b00} + {25'h0, trap_cause, 2'b00}
                            : {mtvec_q[31:2], 2'b00};
    assign mepc           = mepc_q;
    assign mstatus_mie    = mie_bit_q;

endmodule

// File: tb/tb_mcsr_file.sv
// Directed and randomized checks of mcsr_file against a behavioural CSR model.
module tb_mcsr_file;

    logic        clk = 1'b0;
    logic        cpurst;
    logic [11:0] csr_r_index;
    logic [31:0] csr_rdat;
    logic        csr_r_illegal;
    logic        csr_wr_en;
    logic [1:0]  csr_wr_op;
    logic [11:0] csr_wr_index;
    logic [31:0] csr_wr_src;
    logic        csr_wr_illegal;
    logic        trap_en, trap_int, mret, instret_inc;
    logic [4:0]  trap_cause;
    logic [31:0] trap_pc, trap_tval;
    logic        mip_msip, mip_mtip, mip_meip;
    logic [3:0]  lirq;
    logic        g_int;
    logic [4:0]  causecode_int;
    logic [31:0] trap_vector, mepc;
    logic        mstatus_mie;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state
    bit [31:0] m_mie, m_mtvec, m_inh, m_scr, m_mepc, m_mcause, m_mtval;
    bit        m_ie, m_pie;
    bit [63:0] m_cyc, m_ret;

    bit [11:0] idx_list [18] = '{12'hF11, 12'hF14, 12'h300, 12'h301, 12'h304, 12'h305,
                                 12'h320, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
                                 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h7C0, 12'h123};

    mcsr_file dut (
        .clk(clk), .cpurst(cpurst),
        .csr_r_index(csr_r_index), .csr_rdat(csr_rdat), .csr_r_illegal(csr_r_illegal),
        .csr_wr_en(csr_wr_en), .csr_wr_op(csr_wr_op), .csr_wr_index(csr_wr_index),
        .csr_wr_src(csr_wr_src), .csr_wr_illegal(csr_wr_illegal),
        .trap_en(trap_en), .trap_int(trap_int), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .trap_tval(trap_tval), .mret(mret), .instret_inc(instret_inc),
        .mip_msip(mip_msip), .mip_mtip(mip_mtip), .mip_meip(mip_meip), .lirq(lirq),
        .g_int(g_int), .causecode_int(causecode_int), .trap_vector(trap_vector),
        .mepc(mepc), .mstatus_mie(mstatus_mie)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] m_mip();
        bit [31:0] v = 32'h0;
        v[3] = mip_msip; v[7] = mip_mtip; v[11] = mip_meip; v[19:16] = lirq;
        return v;
    endfunction

    function automatic bit [31:0] m_read(input bit [11:0] idx, output bit ok);
        ok = 1'b1;
        case (idx)
            12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h301: return 32'h0;
            12'h300: return 32'h1800 + (32'(m_pie) * 32'd128) + (32'(m_ie) * 32'd8);
            12'h304: return m_mie;
            12'h305: return m_mtvec;
            12'h320: return m_inh;
            12'h340: return m_scr;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return m_mip();
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ret[31:0];
            12'hB82: return m_ret[63:32];
            default: begin ok = 1'b0; return 32'h0; end
        endcase
    endfunction

    function automatic bit m_wr_legal(input bit [11:0] idx);
        bit ok;
        bit [31:0] d;
        d = m_read(idx, ok);
        return ok && !(idx inside {12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h344});
    endfunction

    function automatic bit [4:0] m_cause();
        int pri [7] = '{11, 3, 7, 16, 17, 18, 19};
        bit [31:0] pend = m_mip() & m_mie;
        foreach (pri[k]) if (pend[pri[k]]) return 5'(pri[k]);
        return 5'd0;
    endfunction

    task automatic m_reset();
        m_mie = 0; m_mtvec = 32'h0; m_inh = 0; m_scr = 0; m_mepc = 0;
        m_mcause = 0; m_mtval = 0; m_ie = 0; m_pie = 0; m_cyc = 0; m_ret = 0;
    endtask

    task automatic idle();
        csr_wr_en = 0; csr_wr_op = 2'b00; csr_wr_index = 12'h000; csr_wr_src = 32'h0;
        trap_en = 0; trap_int = 0; trap_cause = 5'd0; trap_pc = 32'h0; trap_tval = 32'h0;
        mret = 0; instret_inc = 0;
    endtask

    // Check all outputs against the model, take one clock edge, advance the model.
    task automatic step();
        bit ok, cw, rw, oinh0, oinh2;
        bit [31:0] er, cur, nv;
        bit [63:0] nc, nr;
        #2;
        er = m_read(csr_r_index, ok);
        chk("rdat", csr_rdat, er);
        chk("r_illegal", {31'h0, csr_r_illegal}, {31'h0, !ok});
        chk("wr_illegal", {31'h0, csr_wr_illegal}, {31'h0, csr_wr_en && !m_wr_legal(csr_wr_index)});
        chk("g_int", {31'h0, g_int}, {31'h0, m_ie && ((m_mip() & m_mie) != 0)});
        chk("causecode", {27'h0, causecode_int}, {27'h0, m_cause()});
        chk("trap_vector", trap_vector, (m_mtvec[1:0] == 2'b01 && trap_int)
            ? (m_mtvec & ~32'h3) + 32'(trap_cause) * 32'd4 : (m_mtvec & ~32'h3));
        chk("mepc", mepc, m_mepc);
        chk("mstatus_mie", {31'h0, mstatus_mie}, {31'h0, m_ie});
        @(posedge clk);
        cur = m_read(csr_wr_index, ok);
        case (csr_wr_op)
            2'b01:   nv = csr_wr_src;
            2'b10:   nv = cur | csr_wr_src;
            2'b11:   nv = cur & ~csr_wr_src;
            default: nv = cur;
        endcase
        oinh0 = m_inh[0]; oinh2 = m_inh[2];
        nc = m_cyc; nr = m_ret; cw = 0; rw = 0;
        if (trap_en) begin
            m_mepc = trap_pc; m_mcause = {trap_int, 26'h0, trap_cause};
            m_mtval = trap_int ? 32'h0 : trap_tval; m_pie = m_ie; m_ie = 0;
        end else if (mret) begin
            m_ie = m_pie; m_pie = 1;
        end else if (csr_wr_en && csr_wr_op != 2'b00 && m_wr_legal(csr_wr_index)) begin
            case (csr_wr_index)
                12'h300: begin m_ie = nv[3]; m_pie = nv[7]; end
                12'h304: m_mie = nv & 32'h000F_0888;
                12'h305: m_mtvec = (nv[1] == 1'b1) ? (nv & ~32'h3) : nv;
                12'h320: m_inh = nv & 32'h5;
                12'h340: m_scr = nv;
                12'h341: m_mepc = nv & ~32'h3;
                12'h342: m_mcause = nv;
                12'h343: m_mtval = nv;
                12'hB00: begin nc = {m_cyc[63:32], nv}; cw = 1; end
                12'hB80: begin nc = {nv, m_cyc[31:0]}; cw = 1; end
                12'hB02: begin nr = {m_ret[63:32], nv}; rw = 1; end
                12'hB82: begin nr = {nv, m_ret[31:0]}; rw = 1; end
                default: ;
            endcase
        end
        if (!cw && !oinh0) nc = m_cyc + 64'd1;
        if (!rw && !oinh2 && instret_inc) nr = m_ret + 64'd1;
        m_cyc = nc; m_ret = nr;
        #1;
    endtask

    task automatic wr(input bit [11:0] idx, input bit [1:0] op, input bit [31:0] src);
        idle();
        csr_wr_en = 1; csr_wr_op = op; csr_wr_index = idx; csr_wr_src = src;
        step();
        idle();
    endtask

    bit [31:0] frozen;

    initial begin
        cpurst = 1; idle(); csr_r_index = 12'h300;
        mip_msip = 0; mip_mtip = 0; mip_meip = 0; lirq = 4'h0;
        m_reset();
        @(posedge clk); @(posedge clk); #1 cpurst = 0;

        // Reset values and illegal read
        #2 chk("rst_mstatus", csr_rdat, 32'h0000_1800);
        chk("rst_g_int", {31'h0, g_int}, 32'h0);
        step();
        csr_r_index = 12'h305; #2 chk("rst_mtvec", csr_rdat, 32'h0); step();
        csr_r_index = 12'h7C0; #2 chk("ill_read", {31'h0, csr_r_illegal}, 32'h1); step();

        // Set/clear and read-only write
        wr(12'h304, 2'b10, 32'h888);
        wr(12'h304, 2'b11, 32'h080);
        csr_r_index = 12'h304; #2 chk("mie_setclr", csr_rdat, 32'h808); step();
        csr_wr_en = 1; csr_wr_op = 2'b01; csr_wr_index = 12'h344; csr_wr_src = 32'hFFFF_FFFF;
        #2 chk("mip_wr_ill", {31'h0, csr_wr_illegal}, 32'h1); step(); idle();
        csr_r_index = 12'h344; #2 chk("mip_unchanged", csr_rdat, 32'h0); step();

        // Trap, vectored target, mret
        wr(12'h305, 2'b01, 32'h1001);
        wr(12'h300, 2'b01, 32'h8);
        trap_en = 1; trap_int = 1; trap_cause = 5'd7; trap_pc = 32'h200;
        #2 chk("trap_vector", trap_vector, 32'h101C); step(); idle();
        csr_r_index = 12'h341; #2 chk("trap_mepc", csr_rdat, 32'h200); step();
        csr_r_index = 12'h342; #2 chk("trap_mcause", csr_rdat, 32'h8000_0007); step();
        csr_r_index = 12'h300; #2 chk("trap_mstatus", csr_rdat, 32'h1880); step();
        mret = 1; step(); idle();
        #2 chk("mret_mstatus", csr_rdat, 32'h1888); step();

        // Interrupt priority
        wr(12'h304, 2'b01, 32'h000F_0888);
        mip_meip = 1; lirq = 4'b0010;
        #2 chk("prio_mei", {27'h0, causecode_int}, 32'd11); chk("g_int_on", {31'h0, g_int}, 32'h1);
        step();
        mip_meip = 0; #2 chk("prio_lirq1", {27'h0, causecode_int}, 32'd17); step();
        wr(12'h300, 2'b11, 32'h8);
        #2 chk("g_int_off", {31'h0, g_int}, 32'h0); step();
        lirq = 4'h0;

        // Counter wrap, write-over-increment, inhibit
        wr(12'hB00, 2'b01, 32'hFFFF_FFFF);
        csr_r_index = 12'hB00; #2 chk("cyc_lo_written", csr_rdat, 32'hFFFF_FFFF); step();
        csr_r_index = 12'hB80; #2 chk("cyc_hi_carry", csr_rdat, 32'h1); step();
        csr_wr_en = 1; csr_wr_op = 2'b01; csr_wr_index = 12'hB02; csr_wr_src = 32'h1234;
        instret_inc = 1; step(); idle();
        csr_r_index = 12'hB02; #2 chk("instret_wr_wins", csr_rdat, 32'h1234); step();
        wr(12'h320, 2'b01, 32'h5);
        csr_r_index = 12'hB00; frozen = m_cyc[31:0];
        for (int i = 0; i < 4; i++) begin instret_inc = 1; step(); end
        idle();
        #2 chk("cyc_frozen", csr_rdat, frozen); step();
        wr(12'h320, 2'b01, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            idle();
            csr_r_index  = idx_list[$urandom_range(0, 17)];
            csr_wr_en    = 1'($urandom_range(0, 1));
            csr_wr_op    = 2'($urandom_range(0, 3));
            csr_wr_index = idx_list[$urandom_range(0, 17)];
            csr_wr_src   = $urandom;
            trap_en      = ($urandom_range(0, 15) == 0);
            mret         = ($urandom_range(0, 15) == 0);
            trap_int     = 1'($urandom_range(0, 1));
            trap_cause   = 5'($urandom_range(0, 31));
            trap_pc      = $urandom;
            trap_tval    = $urandom;
            instret_inc  = 1'($urandom_range(0, 1));
            mip_msip     = 1'($urandom_range(0, 1));
            mip_mtip     = 1'($urandom_range(0, 1));
            mip_meip     = ($urandom_range(0, 3) == 0);
            lirq         = 4'($urandom_range(0, 15));
            step();
        end

        // Asynchronous reset between edges, during a trap
        idle(); wr(12'h304, 2'b01, 32'h888); wr(12'h300, 2'b01, 32'h8);
        mip_msip = 1; trap_en = 1; trap_int = 0; trap_pc = 32'h444; csr_r_index = 12'h300;
        #3 cpurst = 1;
        #1 chk("arst_mstatus", csr_rdat, 32'h1800);
        chk("arst_mepc", mepc, 32'h0);
        chk("arst_g_int", {31'h0, g_int}, 32'h0);
        csr_r_index = 12'hB00; #1 chk("arst_mcycle", csr_rdat, 32'h0);
        m_reset(); idle();
        @(posedge clk); #1 cpurst = 0;
        for (int i = 0; i < 3; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
